// File: rtl/regfile_pkg.sv
// Shared register file constants and write-request types for the writeback arbiter slice.
package regfile_pkg;

    localparam int unsigned REG_ADR_W  = 6;
    localparam int unsigned REG_DATA_W = 64;
    localparam int unsigned REG_COUNT  = 64;
    localparam int unsigned REQ_MAX    = 4;

    typedef struct packed {
        logic [REG_ADR_W-1:0]  adr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic [2:0] count_ones(input logic [REQ_MAX-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < REQ_MAX; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side valid/ready bundle; master = writeback sources, slave = arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADR_W   = 6,
    parameter int unsigned DATA_W  = 64
);
    logic [NUM_REQ-1:0]        reqValid;
    logic [NUM_REQ*ADR_W-1:0]  reqAdr;
    logic [NUM_REQ*DATA_W-1:0] reqData;
    logic [NUM_REQ-1:0]        reqReady;

    modport master (output reqValid, output reqAdr, output reqData, input reqReady);
    modport slave  (input reqValid, input reqAdr, input reqData, output reqReady);
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid request after last_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic        found;
    int unsigned cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_i) + k) % NUM_REQ;
            if (en_i && !found && req_i[IDX_W'(cand)]) begin
                found                = 1'b1;
                gnt_o[IDX_W'(cand)]  = 1'b1;
                idx_o                = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port, with a one-entry commit stage
// and read-hazard flags against the staged write.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADR_W   = REG_ADR_W,
    parameter int unsigned DATA_W  = REG_DATA_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    regfile_write_arbiter_if.slave    req,
    input  logic                      freeze,
    input  logic [ADR_W-1:0]          checkAdr1,
    input  logic [ADR_W-1:0]          checkAdr2,
    output logic                      hazard1,
    output logic                      hazard2,
    output logic [ADR_W-1:0]          writeAdr,
    output logic [DATA_W-1:0]         writeData,
    output logic                      writeEnable,
    output logic [CNT_W-1:0]          conflictCount
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic               stg_valid_q, stg_valid_d;
    logic [ADR_W-1:0]   stg_adr_q, stg_adr_d;
    logic [DATA_W-1:0]  stg_data_q, stg_data_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   conflict_q, conflict_d;

    logic               drain;
    logic               can_accept;
    logic               accept;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [REQ_MAX-1:0] valid_ext;

    // Reset gates the commit so a pending write is discarded rather than written.
    assign drain       = stg_valid_q && !freeze && !reset;
    assign can_accept  = (!stg_valid_q || drain) && !reset;
    assign accept      = |gnt;
    assign valid_ext   = REQ_MAX'(req.reqValid);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i  (req.reqValid),
        .en_i   (can_accept),
        .last_i (last_grant_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    assign req.reqReady = gnt;
    assign writeEnable  = drain;
    assign writeAdr     = stg_adr_q;
    assign writeData    = stg_data_q;
    assign hazard1      = stg_valid_q && !reset && (stg_adr_q == checkAdr1);
    assign hazard2      = stg_valid_q && !reset && (stg_adr_q == checkAdr2);
    assign conflictCount = conflict_q;

    always_comb begin
        stg_valid_d  = stg_valid_q;
        stg_adr_d    = stg_adr_q;
        stg_data_d   = stg_data_q;
        last_grant_d = last_grant_q;
        conflict_d   = conflict_q;
        if (accept) begin
            stg_valid_d  = 1'b1;
            stg_adr_d    = req.reqAdr[gnt_idx*ADR_W +: ADR_W];
            stg_data_d   = req.reqData[gnt_idx*DATA_W +: DATA_W];
            last_grant_d = gnt_idx;
        end else if (drain) begin
            stg_valid_d = 1'b0;
        end
        if ((count_ones(valid_ext) > {2'b00, accept}) && (conflict_q != '1)) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid_q  <= 1'b0;
            stg_adr_q    <= '0;
            stg_data_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            conflict_q   <= '0;
        end else begin
            stg_valid_q  <= stg_valid_d;
            stg_adr_q    <= stg_adr_d;
            stg_data_q   <= stg_data_d;
            last_grant_q <= last_grant_d;
            conflict_q   <= conflict_d;
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 64-entry x 64-bit register file among NUM_REQ writeback sources, e.g. ALU result and memory load.
- Uses round-robin arbitration, a one-entry output stage and a valid/ready handshake per requester.
- Flags read hazards against the staged, not-yet-committed write.
- Sits between the writeback sources and the register file write inputs (writeAdr, writeData, writeEnable).

Parameters:
- NUM_REQ, 2, number of write requesters; legal range 2..4.
- ADR_W, 6, register address width (64 registers).
- DATA_W, 64, register data width.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  NUM_REQ  per-requester write request.
- reqAdr  in  NUM_REQ*ADR_W  packed target addresses; requester i occupies bits [i*ADR_W +: ADR_W].
- reqData  in  NUM_REQ*DATA_W  packed write data, same packing as reqAdr.
- reqReady  out  NUM_REQ  one-hot grant; a transfer occurs when reqValid[i] && reqReady[i].
- freeze  in  1  pipeline freeze; blocks the commit to the register file.
- checkAdr1  in  ADR_W  address being read on register file read port 1.
- checkAdr2  in  ADR_W  address being read on register file read port 2.
- hazard1  out  1  checkAdr1 matches the staged pending write.
- hazard2  out  1  checkAdr2 matches the staged pending write.
- writeAdr  out  ADR_W  to the register file.
- writeData  out  DATA_W  to the register file.
- writeEnable  out  1  to the register file.
- conflictCount  out  CNT_W  number of cycles in which at least one valid requester was not granted.

Behaviour:
- State:
  - Stage: stgValid, stgAdr, stgData.
  - Round-robin pointer lastGrant, log2(NUM_REQ) bits.
  - conflictCount.
- Reset (synchronous, when reset=1 at posedge):
  - stgValid=0, stgAdr=0, stgData=0, lastGrant=NUM_REQ-1 so requester 0 has first priority, conflictCount=0.
  - Outputs: writeEnable=0, reqReady=0, hazard1=hazard2=0, writeAdr=0, writeData=0.
  - A stage holding a pending write at reset is discarded, not committed.
- Commit:
  - writeEnable = stgValid && !freeze (combinational); writeAdr=stgAdr, writeData=stgData.
  - The register file captures the write on the same posedge.
  - drain = writeEnable.
- Accept:
  - canAccept = !stgValid || drain.
  - If canAccept and any reqValid, grant the first valid index searching from lastGrant+1 upward, wrapping modulo NUM_REQ.
  - reqReady is one-hot on the granted index, all-zero otherwise.
  - reqReady depends combinationally on reqValid and freeze; requesters must not make reqValid depend on reqReady.
- Update on posedge:
  - On accept: stage loads the granted reqAdr/reqData, stgValid=1, lastGrant=granted index.
  - On drain without accept: stgValid=0.
  - On drain with accept, the stage is overwritten: back-to-back throughput of one write per cycle.
- Latency: accepted request to writeEnable high is 1 cycle with freeze=0, and is extended by every freeze cycle.
- freeze=1 with stgValid=1: stage holds, reqReady=0, writeEnable=0.
- freeze=1 with stgValid=0: one request may still be accepted into the stage.
- Hazards:
  - hazard1 = stgValid && (stgAdr==checkAdr1); likewise hazard2 with checkAdr2.
  - Combinational; asserted during the cycle before commit, while the register file still holds the old value.
- Same address from two requesters: serialized in grant order; the later grant's data is the final register value.
- Requester contract: must hold reqAdr/reqData stable while reqValid=1 and not granted.
- conflictCount: increments by 1 when popcount(reqValid) > number granted this cycle (0 or 1); saturates at 2^CNT_W-1, no wrap.

Decomposition:
- Shared package regfile_pkg: REG_ADR_W=6, REG_DATA_W=64, REG_COUNT=64, plus a typedef for the {adr,data} write-request struct.
- One natural sub-module, rr_arbiter: parameterized NUM_REQ.
  - Inputs: request vector, enable (canAccept), lastGrant.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> writeEnable=0, reqReady=0, conflictCount=0, hazard1=hazard2=0.
- Single write: req0 valid adr=5 data=0x1234 for one cycle -> reqReady=01 that cycle; next cycle writeEnable=1, writeAdr=5, writeData=0x1234; register 5 reads 0x1234 afterwards.
- Round-robin with continuous requests:
  - Stimulus: req0 adr=1 and req1 adr=2 both held valid for 4 cycles from reset.
  - Required grants: 0,1,0,1.
  - Required writeAdr sequence, one cycle later: 1,2,1,2.
  - Required conflictCount = 4.
- Freeze: stage holds adr=7; freeze=1 for 3 cycles with req1 valid -> writeEnable=0, reqReady=00, stage unchanged, hazard1=1 with checkAdr1=7; freeze drop -> commit of adr 7 and req1 granted in the same cycle.
- Same-address ordering: req0 adr=3 data=0xA and req1 adr=3 data=0xB simultaneously -> two commits, 0xA then 0xB; register 3 ends at 0xB.
- Reset mid-operation: stgValid=1 with adr=9; reset=1 -> no write to register 9, stgValid=0, lastGrant=NUM_REQ-1; next simultaneous request grants req0 first.
